// File: rtl/cv32e40p_obi_mem_responder_if.sv
// OBI request/response bundle between an initiator (core fetch/LSU or bench)
// and the memory responder.
interface cv32e40p_obi_mem_responder_if;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory responder: word RAM with byte-enable writes, fixed-latency in-order
// responses, an outstanding-transaction cap and a grant stall for back-pressure tests.
module cv32e40p_obi_mem_responder #(
   parameter int unsigned ADDR_WIDTH      = 12,
   parameter int unsigned RESP_LAT        = 1,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               stall_i,
   cv32e40p_obi_mem_responder_if.slave        obi
);

   localparam int unsigned      DEPTH   = 2**ADDR_WIDTH;
   localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [31:0]           mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [31:0]           rd_word;
   logic                  accept;
   logic                  resp_fire;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [RESP_LAT-1:0]   vld_q, vld_d;
   logic [31:0]           dat_q [RESP_LAT];
   logic [31:0]           dat_d [RESP_LAT];

   logic                  unused_addr;

   // Byte offset and bits above the RAM are dropped, so addresses alias.
   assign word_idx    = obi.addr[ADDR_WIDTH+1:2];
   assign unused_addr = ^{obi.addr[31:ADDR_WIDTH+2], obi.addr[1:0]};
   assign rd_word     = mem_q[word_idx];

   assign resp_fire   = vld_q[RESP_LAT-1];
   assign obi.gnt     = obi.req & ~stall_i & ((cnt_q < CNT_MAX) | resp_fire);
   assign accept      = obi.req & obi.gnt;

   assign obi.rvalid  = resp_fire;
   assign obi.rdata   = resp_fire ? dat_q[RESP_LAT-1] : 32'h0;

   always_comb begin
      vld_d    = '0;
      dat_d    = '{default: '0};
      vld_d[0] = accept;
      // Read data is captured at the accept edge; writes answer with zero.
      dat_d[0] = (accept && !obi.we) ? rd_word : 32'h0;
      for (int i = 1; i < int'(RESP_LAT); i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, resp_fire})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         vld_q <= '0;
         for (int i = 0; i < int'(RESP_LAT); i++) begin
            dat_q[i] <= 32'h0;
         end
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
         for (int i = 0; i < int'(RESP_LAT); i++) begin
            dat_q[i] <= dat_d[i];
         end
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk_i) begin
      if (accept && obi.we) begin
         for (int k = 0; k < 4; k++) begin
            if (obi.be[k]) begin
               mem_q[word_idx][8*k +: 8] <= obi.wdata[8*k +: 8];
            end
         end
      end
   end

   property p_req_stable;
      @(posedge clk_i) disable iff (!rst_ni)
         (obi.req && !obi.gnt) |=> ($stable(obi.addr) && $stable(obi.we) &&
                                    $stable(obi.be)   && $stable(obi.wdata));
   endproperty
   a_req_stable: assert property (p_req_stable);

   a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q <= CNT_MAX);

   a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      resp_fire |-> (cnt_q != '0));

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Directed bench: dut1 (ADDR_WIDTH=4, RESP_LAT=1) for data/byte-enable/alias cases,
// dut3 (RESP_LAT=3, MAX_OUTSTANDING=2) for pipelining, stall and mid-flight reset.
module tb_cv32e40p_obi_mem_responder;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   logic stall1  = 1'b0;
   logic stall3  = 1'b0;
   int   n_chk   = 0;
   int   n_err   = 0;

   cv32e40p_obi_mem_responder_if bus1();
   cv32e40p_obi_mem_responder_if bus3();

   cv32e40p_obi_mem_responder #(
      .ADDR_WIDTH     (4),
      .RESP_LAT       (1),
      .MAX_OUTSTANDING(2)
   ) dut1 (
      .clk_i  (clk_sys),
      .rst_ni (rst_n),
      .stall_i(stall1),
      .obi    (bus1)
   );

   cv32e40p_obi_mem_responder #(
      .ADDR_WIDTH     (12),
      .RESP_LAT       (3),
      .MAX_OUTSTANDING(2)
   ) dut3 (
      .clk_i  (clk_sys),
      .rst_ni (rst_n),
      .stall_i(stall3),
      .obi    (bus3)
   );

   always #5 clk_sys = ~clk_sys;

   localparam logic [31:0] D1 = 32'h1111_0001;
   localparam logic [31:0] D2 = 32'h2222_0002;
   localparam logic [31:0] D3 = 32'h3333_0003;
   localparam logic [31:0] D4 = 32'h4444_0004;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle1();
      bus1.req = 1'b0; bus1.we = 1'b0; bus1.be = 4'h0; bus1.addr = 32'h0; bus1.wdata = 32'h0;
   endtask

   task automatic idle3();
      bus3.req = 1'b0; bus3.we = 1'b0; bus3.be = 4'h0; bus3.addr = 32'h0; bus3.wdata = 32'h0;
   endtask

   // Single RESP_LAT=1 transaction; entered and left just after a rising edge.
   task automatic xfer1(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] exp);
      bus1.req = 1'b1; bus1.we = we; bus1.addr = addr; bus1.be = be; bus1.wdata = wdata;
      @(negedge clk_sys);
      check({tag, "_gnt"}, bus1.gnt, 32'h1);
      tick();
      idle1();
      @(negedge clk_sys);
      check({tag, "_rv"}, bus1.rvalid, 32'h1);
      check({tag, "_rd"}, bus1.rdata, exp);
      tick();
   endtask

   // Single RESP_LAT=3 transaction from idle: response exactly 3 cycles after accept.
   task automatic xfer3(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] exp);
      bus3.req = 1'b1; bus3.we = we; bus3.addr = addr; bus3.be = be; bus3.wdata = wdata;
      @(negedge clk_sys);
      check({tag, "_gnt"}, bus3.gnt, 32'h1);
      tick();
      idle3();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_sys);
         check($sformatf("%s_rv%0d", tag, c), bus3.rvalid, (c == 3) ? 32'h1 : 32'h0);
         check($sformatf("%s_rd%0d", tag, c), bus3.rdata, (c == 3) ? exp : 32'h0);
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        eg [5];
      logic        ev [9];
      logic [31:0] ed [9];
      logic        g;
      int          idx;

      idle1();
      idle3();
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst_rv1", bus1.rvalid, 32'h0);
      check("rst_rd1", bus1.rdata, 32'h0);
      check("rst_rv3", bus3.rvalid, 32'h0);
      check("rst_rd3", bus3.rdata, 32'h0);
      rst_n = 1'b1;
      tick();

      // Write then read of the same word on consecutive accepts
      bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 32'h100; bus1.be = 4'hF; bus1.wdata = 32'hDEADBEEF;
      @(negedge clk_sys);
      check("wr_gnt", bus1.gnt, 32'h1);
      tick();
      bus1.we = 1'b0; bus1.be = 4'h0; bus1.wdata = 32'h0;
      @(negedge clk_sys);
      check("rd_gnt", bus1.gnt, 32'h1);
      check("wr_rv", bus1.rvalid, 32'h1);
      check("wr_rd", bus1.rdata, 32'h0);
      tick();
      idle1();
      @(negedge clk_sys);
      check("rd_rv", bus1.rvalid, 32'h1);
      check("rd_rd", bus1.rdata, 32'hDEADBEEF);
      tick();
      @(negedge clk_sys);
      check("idle_rv", bus1.rvalid, 32'h0);
      check("idle_rd", bus1.rdata, 32'h0);
      tick();

      // Byte enables
      xfer1("pre",   1'b1, 32'h0, 4'hF, 32'h11223344, 32'h0);
      xfer1("be5",   1'b1, 32'h0, 4'h5, 32'hAABBCCDD, 32'h0);
      xfer1("rdbe5", 1'b0, 32'h0, 4'h0, 32'h0,        32'h11BB33DD);
      xfer1("be0",   1'b1, 32'h0, 4'h0, 32'hFFFFFFFF, 32'h0);
      xfer1("rdbe0", 1'b0, 32'h0, 4'h0, 32'h0,        32'h11BB33DD);

      // Aliasing with 16 words: 0x40 -> word 0, 0x47 -> word 1
      xfer1("al_wr0", 1'b1, 32'h0,  4'hF, 32'h5,  32'h0);
      xfer1("al_wr1", 1'b1, 32'h4,  4'hF, 32'h77, 32'h0);
      xfer1("al_rd0", 1'b0, 32'h40, 4'h0, 32'h0,  32'h5);
      xfer1("al_rd1", 1'b0, 32'h47, 4'h0, 32'h0,  32'h77);

      // Preload dut3
      xfer3("pl0", 1'b1, 32'h10, 4'hF, D1, 32'h0);
      xfer3("pl1", 1'b1, 32'h14, 4'hF, D2, 32'h0);
      xfer3("pl2", 1'b1, 32'h18, 4'hF, D3, 32'h0);
      xfer3("pl3", 1'b1, 32'h1C, 4'hF, D4, 32'h0);

      // Four back-to-back reads with req held high
      eg = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      ed = '{32'h0, 32'h0, 32'h0, D1, D2, 32'h0, D3, D4, 32'h0};
      idx = 0;
      bus3.req = 1'b1; bus3.we = 1'b0; bus3.addr = 32'h10;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk_sys);
         if (c < 5) check($sformatf("b2b_gnt%0d", c), bus3.gnt, eg[c]);
         check($sformatf("b2b_rv%0d", c), bus3.rvalid, ev[c]);
         check($sformatf("b2b_rd%0d", c), bus3.rdata, ed[c]);
         g = bus3.gnt;
         tick();
         if (bus3.req && g) begin
            idx++;
            if (idx == 4) idle3();
            else bus3.addr = 32'h10 + 32'(4 * idx);
         end
      end
      idle3();

      // Stall for 5 cycles with one read in flight and one pending
      bus3.req = 1'b1; bus3.we = 1'b0; bus3.addr = 32'h18;
      @(negedge clk_sys);
      check("st_gnt0", bus3.gnt, 32'h1);
      tick();
      bus3.addr = 32'h1C;
      stall3 = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk_sys);
         check($sformatf("st_gnt%0d", c), bus3.gnt, 32'h0);
         check($sformatf("st_rv%0d", c), bus3.rvalid, (c == 3) ? 32'h1 : 32'h0);
         check($sformatf("st_rd%0d", c), bus3.rdata, (c == 3) ? D3 : 32'h0);
      end
      tick();
      stall3 = 1'b0;
      @(negedge clk_sys);
      check("st_gnt6", bus3.gnt, 32'h1);
      tick();
      idle3();
      for (int c = 7; c <= 9; c++) begin
         @(negedge clk_sys);
         check($sformatf("st_rv%0d", c), bus3.rvalid, (c == 9) ? 32'h1 : 32'h0);
         check($sformatf("st_rd%0d", c), bus3.rdata, (c == 9) ? D4 : 32'h0);
      end
      tick();

      // Reset with two reads in flight
      bus3.req = 1'b1; bus3.we = 1'b0; bus3.addr = 32'h10;
      @(negedge clk_sys);
      check("rs_gnt0", bus3.gnt, 32'h1);
      tick();
      bus3.addr = 32'h14;
      @(negedge clk_sys);
      check("rs_gnt1", bus3.gnt, 32'h1);
      tick();
      idle3();
      @(negedge clk_sys);
      check("rs_rv2", bus3.rvalid, 32'h0);
      tick();
      check("rs_rv_pre", bus3.rvalid, 32'h1);
      rst_n = 1'b0;
      #1;
      check("rs_rv_now", bus3.rvalid, 32'h0);
      check("rs_rd_now", bus3.rdata, 32'h0);
      tick();
      check("rs_rv4", bus3.rvalid, 32'h0);
      @(negedge clk_sys);
      rst_n = 1'b1;
      tick();
      bus3.req = 1'b1; bus3.we = 1'b0; bus3.addr = 32'h1C;
      @(negedge clk_sys);
      check("rs_gnt5", bus3.gnt, 32'h1);
      check("rs_rv5", bus3.rvalid, 32'h0);
      tick();
      idle3();
      for (int c = 6; c <= 8; c++) begin
         @(negedge clk_sys);
         check($sformatf("rs_rv%0d", c), bus3.rvalid, (c == 8) ? 32'h1 : 32'h0);
         check($sformatf("rs_rd%0d", c), bus3.rdata, (c == 8) ? D4 : 32'h0);
      end
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
